// File: rtl/ahb_defs.sv
// ----------------------------------------------------------------------------
// Module   : ahb_defs
// Purpose  : Shared AHB-Lite encodings and address-phase control bundle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BYTE     = 3'b000,
        HALFWORD = 3'b001,
        WORD     = 3'b010
    } hsize_t;

    localparam logic [2:0] SINGLE     = 3'b000;
    localparam logic [3:0] HPROT_DATA = 4'b0001;

    // HMASTER encoding on the shared port
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [3:0] prot;
    } ahb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ahb_req_buffer.sv
// ----------------------------------------------------------------------------
// Module   : ahb_req_buffer
// Purpose  : One-entry address-phase holding buffer and source mux for a master.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_req_buffer
    import ahb_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              live,
    input  logic              issue,
    input  logic [ADDR_W-1:0] addr_in,
    input  ahb_ctrl_t         ctrl_in,
    output logic              pend,
    output logic              req,
    output logic [ADDR_W-1:0] addr_src,
    output ahb_ctrl_t         ctrl_src
);

    logic [ADDR_W-1:0] addr_q;
    ahb_ctrl_t         ctrl_q;

    // A live request that is not issued this cycle is parked; the master then
    // sees HREADY low, so a second capture cannot occur while pend is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            addr_q <= '0;
            ctrl_q <= '0;
        end else if (live && !issue) begin
            pend   <= 1'b1;
            addr_q <= addr_in;
            ctrl_q <= ctrl_in;
        end else if (issue) begin
            pend   <= 1'b0;
        end
    end

    assign req      = pend | live;
    assign addr_src = pend ? addr_q : addr_in;
    assign ctrl_src = pend ? ctrl_q : ctrl_in;

endmodule

`default_nettype wire

// File: rtl/ahb_im_dm_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : ahb_im_dm_arbiter
// Purpose  : Two-master (fetch I, data D) to one-slave AHB-Lite arbiter with
//            D priority and a starvation limit guaranteeing fetch progress.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_im_dm_arbiter
    import ahb_defs::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] HADDR_I,
    input  logic [1:0]        HTRANS_I,
    input  logic              HWRITE_I,
    input  logic [2:0]        HSIZE_I,
    input  logic [3:0]        HPROT_I,
    input  logic [ADDR_W-1:0] HADDR_D,
    input  logic [1:0]        HTRANS_D,
    input  logic              HWRITE_D,
    input  logic [2:0]        HSIZE_D,
    input  logic [3:0]        HPROT_D,
    input  logic [DATA_W-1:0] HWDATA_D,
    output logic              HREADY_I,
    output logic              HREADY_D,
    output logic              HRESP_I,
    output logic              HRESP_D,
    output logic [DATA_W-1:0] HRDATA_I,
    output logic [DATA_W-1:0] HRDATA_D,
    output logic [ADDR_W-1:0] HADDR_S,
    output logic [1:0]        HTRANS_S,
    output logic              HWRITE_S,
    output logic [2:0]        HSIZE_S,
    output logic [3:0]        HPROT_S,
    output logic [2:0]        HBURST_S,
    output logic              HMASTLOCK_S,
    output logic              HMASTER_S,
    output logic [DATA_W-1:0] HWDATA_S,
    input  logic [DATA_W-1:0] HRDATA_S,
    input  logic              HREADY_S,
    input  logic              HRESP_S
);

    localparam int              CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic              live_i, live_d;
    logic              pend_i, pend_d;
    logic              req_i, req_d;
    logic              win_i, win_d;
    logic              slot, starve;
    logic [ADDR_W-1:0] addr_src_i, addr_src_d;
    ahb_ctrl_t         ctrl_in_i, ctrl_in_d;
    ahb_ctrl_t         ctrl_src_i, ctrl_src_d;
    logic              dp_valid;
    logic              dp_owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic              own_i, own_d;
    logic              unused_htrans_lsb;

    // BUSY folds into IDLE and SEQ into NONSEQ, so only HTRANS[1] matters.
    assign unused_htrans_lsb = HTRANS_I[0] ^ HTRANS_D[0];

    assign live_i    = HTRANS_I[1] & HREADY_I;
    assign live_d    = HTRANS_D[1] & HREADY_D;
    assign ctrl_in_i = '{write: HWRITE_I, size: HSIZE_I, prot: HPROT_I};
    assign ctrl_in_d = '{write: HWRITE_D, size: HSIZE_D, prot: HPROT_D};

    ahb_req_buffer #(.ADDR_W(ADDR_W)) u_buf_i (
        .clk      (CLK),
        .rst_n    (RSTn),
        .live     (live_i),
        .issue    (win_i),
        .addr_in  (HADDR_I),
        .ctrl_in  (ctrl_in_i),
        .pend     (pend_i),
        .req      (req_i),
        .addr_src (addr_src_i),
        .ctrl_src (ctrl_src_i)
    );

    ahb_req_buffer #(.ADDR_W(ADDR_W)) u_buf_d (
        .clk      (CLK),
        .rst_n    (RSTn),
        .live     (live_d),
        .issue    (win_d),
        .addr_in  (HADDR_D),
        .ctrl_in  (ctrl_in_d),
        .pend     (pend_d),
        .req      (req_d),
        .addr_src (addr_src_d),
        .ctrl_src (ctrl_src_d)
    );

    assign slot   = HREADY_S;
    assign starve = (STARVE_LIMIT != 0) && (wait_cnt >= LIMIT_C);
    assign win_d  = slot & req_d & ~(starve & req_i);
    assign win_i  = slot & req_i & ~win_d;

    always_comb begin
        HTRANS_S  = IDLE;
        HMASTER_S = OWNER_I;
        HADDR_S   = addr_src_i;
        HWRITE_S  = ctrl_src_i.write;
        HSIZE_S   = ctrl_src_i.size;
        HPROT_S   = ctrl_src_i.prot;
        if (win_d) begin
            HTRANS_S  = NONSEQ;
            HMASTER_S = OWNER_D;
            HADDR_S   = addr_src_d;
            HWRITE_S  = ctrl_src_d.write;
            HSIZE_S   = ctrl_src_d.size;
            HPROT_S   = ctrl_src_d.prot;
        end else if (win_i) begin
            HTRANS_S  = NONSEQ;
        end
    end

    assign HBURST_S    = SINGLE;
    assign HMASTLOCK_S = 1'b0;

    // wait_cnt counts slots I lost while requesting; it saturates at the limit.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dp_valid <= 1'b0;
            dp_owner <= OWNER_I;
            wait_cnt <= '0;
        end else if (slot) begin
            dp_valid <= win_i | win_d;
            dp_owner <= win_d ? OWNER_D : OWNER_I;
            if (win_i) begin
                wait_cnt <= '0;
            end else if (req_i && (wait_cnt < LIMIT_C)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign own_i = dp_valid & (dp_owner == OWNER_I);
    assign own_d = dp_valid & (dp_owner == OWNER_D);

    assign HREADY_I = own_i ? HREADY_S : ~pend_i;
    assign HREADY_D = own_d ? HREADY_S : ~pend_d;
    assign HRESP_I  = own_i & HRESP_S;
    assign HRESP_D  = own_d & HRESP_S;
    assign HRDATA_I = HRDATA_S;
    assign HRDATA_D = HRDATA_S;
    assign HWDATA_S = own_d ? HWDATA_D : '0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_im_dm_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : tb_ahb_im_dm_arbiter
// Purpose  : Directed self-checking bench for the I/D AHB-Lite arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ahb_im_dm_arbiter;
    import ahb_defs::*;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] haddr_i, haddr_d, hwdata_d, hrdata_s;
    logic [1:0]  htrans_i, htrans_d;
    logic        hwrite_i, hwrite_d;
    logic [2:0]  hsize_i, hsize_d;
    logic [3:0]  hprot_i, hprot_d;
    logic        hready_s, hresp_s;

    logic        HREADY_I, HREADY_D, HRESP_I, HRESP_D;
    logic [31:0] HRDATA_I, HRDATA_D, HADDR_S, HWDATA_S;
    logic [1:0]  HTRANS_S;
    logic        HWRITE_S, HMASTLOCK_S, HMASTER_S;
    logic [2:0]  HSIZE_S, HBURST_S;
    logic [3:0]  HPROT_S;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ahb_im_dm_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .HADDR_I(haddr_i), .HTRANS_I(htrans_i), .HWRITE_I(hwrite_i), .HSIZE_I(hsize_i), .HPROT_I(hprot_i),
        .HADDR_D(haddr_d), .HTRANS_D(htrans_d), .HWRITE_D(hwrite_d), .HSIZE_D(hsize_d), .HPROT_D(hprot_d),
        .HWDATA_D(hwdata_d),
        .HREADY_I(HREADY_I), .HREADY_D(HREADY_D), .HRESP_I(HRESP_I), .HRESP_D(HRESP_D),
        .HRDATA_I(HRDATA_I), .HRDATA_D(HRDATA_D),
        .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S), .HSIZE_S(HSIZE_S), .HPROT_S(HPROT_S),
        .HBURST_S(HBURST_S), .HMASTLOCK_S(HMASTLOCK_S), .HMASTER_S(HMASTER_S), .HWDATA_S(HWDATA_S),
        .HRDATA_S(hrdata_s), .HREADY_S(hready_s), .HRESP_S(hresp_s)
    );

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic all_idle;
        htrans_i = IDLE;
        htrans_d = IDLE;
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        haddr_i = '0; htrans_i = IDLE; hwrite_i = 1'b0; hsize_i = WORD; hprot_i = 4'b0000;
        haddr_d = '0; htrans_d = IDLE; hwrite_d = 1'b0; hsize_d = WORD; hprot_d = HPROT_DATA;
        hwdata_d = '0; hrdata_s = '0; hready_s = 1'b1; hresp_s = 1'b0;
        #2;
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %0h want 0", HTRANS_S); end
        n_checks++; if (HREADY_I !== 1'b1) begin n_fail++; $display("FAIL reset_hready_i: got %0b want 1", HREADY_I); end
        n_checks++; if (HREADY_D !== 1'b1) begin n_fail++; $display("FAIL reset_hready_d: got %0b want 1", HREADY_D); end
        n_checks++; if ({HRESP_I, HRESP_D} !== 2'b00) begin n_fail++; $display("FAIL reset_hresp: got %0b want 00", {HRESP_I, HRESP_D}); end
        n_checks++; if (HMASTER_S !== 1'b0) begin n_fail++; $display("FAIL reset_hmaster: got %0b want 0", HMASTER_S); end
        n_checks++; if (HWDATA_S !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata: got %0h want 0", HWDATA_S); end
        step;
        step;
        RSTn = 1'b1;
        step;
    endtask

    task automatic test_single_d;
        htrans_d = NONSEQ; haddr_d = 32'h100; hwrite_d = 1'b0;
        #1;
        n_checks++; if (HTRANS_S !== 2'b10) begin n_fail++; $display("FAIL single_htrans: got %0h want 2", HTRANS_S); end
        n_checks++; if (HADDR_S !== 32'h100) begin n_fail++; $display("FAIL single_haddr: got %0h want 100", HADDR_S); end
        n_checks++; if (HMASTER_S !== 1'b1) begin n_fail++; $display("FAIL single_hmaster: got %0b want 1", HMASTER_S); end
        n_checks++; if (HREADY_D !== 1'b1) begin n_fail++; $display("FAIL single_hready_a: got %0b want 1", HREADY_D); end
        n_checks++; if (HPROT_S !== 4'b0001) begin n_fail++; $display("FAIL single_hprot: got %0h want 1", HPROT_S); end
        n_checks++; if (HSIZE_S !== 3'b010) begin n_fail++; $display("FAIL single_hsize: got %0h want 2", HSIZE_S); end
        step;
        htrans_d = IDLE; hrdata_s = 32'h1234_5678;
        #1;
        n_checks++; if (HRDATA_D !== 32'h1234_5678) begin n_fail++; $display("FAIL single_hrdata: got %0h want 12345678", HRDATA_D); end
        n_checks++; if (HREADY_D !== 1'b1) begin n_fail++; $display("FAIL single_hready_b: got %0b want 1", HREADY_D); end
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %0h want 0", HTRANS_S); end
        step;
    endtask

    task automatic test_simultaneous;
        htrans_i = NONSEQ; haddr_i = 32'h0;
        htrans_d = NONSEQ; haddr_d = 32'h200;
        #1;
        n_checks++; if (HADDR_S !== 32'h200 || HMASTER_S !== 1'b1) begin n_fail++; $display("FAIL simul_first: got addr %0h mst %0b want 200/1", HADDR_S, HMASTER_S); end
        n_checks++; if (HREADY_I !== 1'b1) begin n_fail++; $display("FAIL simul_hready_i_a: got %0b want 1", HREADY_I); end
        step;
        haddr_i = 32'h4; htrans_d = IDLE;
        #1;
        n_checks++; if (HREADY_I !== 1'b0) begin n_fail++; $display("FAIL simul_hready_i_b: got %0b want 0", HREADY_I); end
        n_checks++; if (HADDR_S !== 32'h0 || HMASTER_S !== 1'b0 || HTRANS_S !== 2'b10) begin n_fail++; $display("FAIL simul_buffered: got addr %0h mst %0b tr %0h want 0/0/2", HADDR_S, HMASTER_S, HTRANS_S); end
        n_checks++; if (HPROT_S !== 4'b0000) begin n_fail++; $display("FAIL simul_hprot: got %0h want 0", HPROT_S); end
        n_checks++; if (HREADY_D !== 1'b1) begin n_fail++; $display("FAIL simul_hready_d: got %0b want 1", HREADY_D); end
        step;
        #1;
        n_checks++; if (HREADY_I !== 1'b1) begin n_fail++; $display("FAIL simul_hready_i_c: got %0b want 1", HREADY_I); end
        n_checks++; if (HADDR_S !== 32'h4 || HMASTER_S !== 1'b0) begin n_fail++; $display("FAIL simul_live: got addr %0h mst %0b want 4/0", HADDR_S, HMASTER_S); end
        step;
        all_idle;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL simul_idle: got %0h want 0", HTRANS_S); end
        step;
    endtask

    task automatic test_starvation;
        logic [9:0] exp_mst, exp_rdy_d, exp_rdy_i;
        exp_mst   = 10'b0111101111;
        exp_rdy_d = 10'b1111011111;
        exp_rdy_i = 10'b0000100001;
        htrans_i = NONSEQ; haddr_i = 32'h1000;
        htrans_d = NONSEQ; haddr_d = 32'h2000;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (HMASTER_S !== exp_mst[k]) begin n_fail++; $display("FAIL starve_hmaster[%0d]: got %0b want %0b", k, HMASTER_S, exp_mst[k]); end
            n_checks++; if (HREADY_D !== exp_rdy_d[k]) begin n_fail++; $display("FAIL starve_hready_d[%0d]: got %0b want %0b", k, HREADY_D, exp_rdy_d[k]); end
            n_checks++; if (HREADY_I !== exp_rdy_i[k]) begin n_fail++; $display("FAIL starve_hready_i[%0d]: got %0b want %0b", k, HREADY_I, exp_rdy_i[k]); end
            step;
        end
        all_idle;
        #1;
        n_checks++; if (HMASTER_S !== 1'b1 || HTRANS_S !== 2'b10 || HADDR_S !== 32'h2000) begin n_fail++; $display("FAIL starve_drain: got mst %0b tr %0h addr %0h want 1/2/2000", HMASTER_S, HTRANS_S, HADDR_S); end
        step;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL starve_idle: got %0h want 0", HTRANS_S); end
        step;
    endtask

    task automatic test_wait_store;
        htrans_i = NONSEQ; haddr_i = 32'h40;
        #1;
        n_checks++; if (HMASTER_S !== 1'b0 || HADDR_S !== 32'h40) begin n_fail++; $display("FAIL store_ifetch: got mst %0b addr %0h want 0/40", HMASTER_S, HADDR_S); end
        step;
        htrans_i = IDLE; hready_s = 1'b0;
        htrans_d = NONSEQ; haddr_d = 32'h300; hwrite_d = 1'b1;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL store_noslot: got %0h want 0", HTRANS_S); end
        n_checks++; if (HREADY_I !== 1'b0 || HREADY_D !== 1'b1) begin n_fail++; $display("FAIL store_ready_b: got i %0b d %0b want 0/1", HREADY_I, HREADY_D); end
        step;
        htrans_d = IDLE; hwdata_d = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (HREADY_D !== 1'b0) begin n_fail++; $display("FAIL store_hready_d_wait[%0d]: got %0b want 0", k, HREADY_D); end
            n_checks++; if (HTRANS_S !== 2'b00 || HWDATA_S !== 32'h0) begin n_fail++; $display("FAIL store_hold[%0d]: got tr %0h wd %0h want 0/0", k, HTRANS_S, HWDATA_S); end
            step;
        end
        hready_s = 1'b1;
        #1;
        n_checks++; if (HTRANS_S !== 2'b10 || HADDR_S !== 32'h300 || HWRITE_S !== 1'b1 || HMASTER_S !== 1'b1) begin n_fail++; $display("FAIL store_issue: got tr %0h addr %0h wr %0b mst %0b want 2/300/1/1", HTRANS_S, HADDR_S, HWRITE_S, HMASTER_S); end
        n_checks++; if (HREADY_I !== 1'b1 || HREADY_D !== 1'b0) begin n_fail++; $display("FAIL store_ready_e: got i %0b d %0b want 1/0", HREADY_I, HREADY_D); end
        step;
        #1;
        n_checks++; if (HWDATA_S !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_hwdata: got %0h want deadbeef", HWDATA_S); end
        n_checks++; if (HREADY_D !== 1'b1 || HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL store_done: got rdy %0b tr %0h want 1/0", HREADY_D, HTRANS_S); end
        step;
        hwdata_d = '0; hwrite_d = 1'b0;
    endtask

    task automatic test_error;
        htrans_i = NONSEQ; haddr_i = 32'h600;
        htrans_d = NONSEQ; haddr_d = 32'h500;
        #1;
        n_checks++; if (HMASTER_S !== 1'b1 || HADDR_S !== 32'h500) begin n_fail++; $display("FAIL err_dfirst: got mst %0b addr %0h want 1/500", HMASTER_S, HADDR_S); end
        step;
        all_idle; hready_s = 1'b0; hresp_s = 1'b1;
        #1;
        n_checks++; if (HRESP_D !== 1'b1 || HRESP_I !== 1'b0) begin n_fail++; $display("FAIL err_resp1: got d %0b i %0b want 1/0", HRESP_D, HRESP_I); end
        n_checks++; if (HREADY_D !== 1'b0 || HREADY_I !== 1'b0 || HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL err_wait1: got d %0b i %0b tr %0h want 0/0/0", HREADY_D, HREADY_I, HTRANS_S); end
        step;
        hready_s = 1'b1;
        #1;
        n_checks++; if (HRESP_D !== 1'b1 || HRESP_I !== 1'b0 || HREADY_D !== 1'b1) begin n_fail++; $display("FAIL err_resp2: got d %0b i %0b rdy %0b want 1/0/1", HRESP_D, HRESP_I, HREADY_D); end
        n_checks++; if (HADDR_S !== 32'h600 || HMASTER_S !== 1'b0 || HTRANS_S !== 2'b10) begin n_fail++; $display("FAIL err_ipend: got addr %0h mst %0b tr %0h want 600/0/2", HADDR_S, HMASTER_S, HTRANS_S); end
        step;
        hready_s = 1'b0;
        #1;
        n_checks++; if (HRESP_I !== 1'b1 || HRESP_D !== 1'b0 || HREADY_I !== 1'b0) begin n_fail++; $display("FAIL err_iresp1: got i %0b d %0b rdy %0b want 1/0/0", HRESP_I, HRESP_D, HREADY_I); end
        step;
        hready_s = 1'b1;
        #1;
        n_checks++; if (HRESP_I !== 1'b1 || HREADY_I !== 1'b1) begin n_fail++; $display("FAIL err_iresp2: got resp %0b rdy %0b want 1/1", HRESP_I, HREADY_I); end
        step;
        hresp_s = 1'b0;
    endtask

    task automatic test_reset_mid;
        htrans_i = NONSEQ; haddr_i = 32'h800;
        htrans_d = NONSEQ; haddr_d = 32'h700;
        #1;
        n_checks++; if (HMASTER_S !== 1'b1 || HADDR_S !== 32'h700) begin n_fail++; $display("FAIL rmid_issue: got mst %0b addr %0h want 1/700", HMASTER_S, HADDR_S); end
        step;
        all_idle; hready_s = 1'b0; hresp_s = 1'b1; hwdata_d = 32'hCAFE_F00D;
        #1;
        n_checks++; if (HREADY_I !== 1'b0 || HWDATA_S !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rmid_before: got rdy_i %0b wd %0h want 0/cafef00d", HREADY_I, HWDATA_S); end
        RSTn = 1'b0;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00 || HMASTER_S !== 1'b0 || HWDATA_S !== 32'h0) begin n_fail++; $display("FAIL rmid_out: got tr %0h mst %0b wd %0h want 0/0/0", HTRANS_S, HMASTER_S, HWDATA_S); end
        n_checks++; if (HREADY_I !== 1'b1 || HREADY_D !== 1'b1 || HRESP_I !== 1'b0 || HRESP_D !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got ri %0b rd %0b pi %0b pd %0b want 1/1/0/0", HREADY_I, HREADY_D, HRESP_I, HRESP_D); end
        n_checks++; if (HBURST_S !== 3'b000 || HMASTLOCK_S !== 1'b0) begin n_fail++; $display("FAIL rmid_const: got burst %0h lock %0b want 0/0", HBURST_S, HMASTLOCK_S); end
        step;
        RSTn = 1'b1; hready_s = 1'b1; hresp_s = 1'b0; hwdata_d = '0;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00 || HREADY_I !== 1'b1) begin n_fail++; $display("FAIL rmid_nostale1: got tr %0h rdy_i %0b want 0/1", HTRANS_S, HREADY_I); end
        step;
        #1;
        n_checks++; if (HTRANS_S !== 2'b00) begin n_fail++; $display("FAIL rmid_nostale2: got %0h want 0", HTRANS_S); end
        step;
    endtask

    initial begin
        test_reset;
        test_single_d;
        test_simultaneous;
        test_starvation;
        test_wait_store;
        test_error;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_im_dm_arbiter.md
Name: ahb_im_dm_arbiter

Overview:
Two-master to one-slave AHB-Lite arbiter. It shares the single system AHB port between the instruction-fetch master (I) and the memory-stage data master (D).
- Each master gets a one-entry address-phase holding buffer, so a master that loses arbitration sees a normal AHB-Lite wait state and never needs a grant signal.
- Fixed priority: D over I, with a starvation limit that guarantees fetch progress.
- Sits between the core's two AHB master ports and the shared bus/slave decoder.

Parameters:
STARVE_LIMIT, 4, consecutive lost arbitration slots after which I wins one slot; 0 disables (strict D priority)
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA/HRDATA width

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  reset, asynchronous, active-low
HADDR_I, HADDR_D  in  ADDR_W  master address
HTRANS_I, HTRANS_D  in  2  master transfer type
HWRITE_I, HWRITE_D  in  1  master write
HSIZE_I, HSIZE_D  in  3  master size
HPROT_I, HPROT_D  in  4  master protection
HWDATA_D  in  DATA_W  D write data (I is read-only)
HREADY_I, HREADY_D  out  1  per-master ready
HRESP_I, HRESP_D  out  1  per-master response
HRDATA_I, HRDATA_D  out  DATA_W  read data, both = HRDATA_S
HADDR_S, HWRITE_S, HSIZE_S, HPROT_S  out  ADDR_W/1/3/4  slave address phase
HTRANS_S  out  2  IDLE or NONSEQ only
HBURST_S  out  3  constant SINGLE
HMASTLOCK_S  out  1  constant 0
HMASTER_S  out  1  address-phase owner, 0=I, 1=D
HWDATA_S  out  DATA_W  write data routed from D
HRDATA_S  in  DATA_W  slave read data
HREADY_S  in  1  slave ready
HRESP_S  in  1  slave response

Behaviour:
- Reset values: pend_I = pend_D = 0; dp_valid = 0; wait_cnt = 0; HTRANS_S = IDLE; HREADY_I = HREADY_D = 1; HRESP_I = HRESP_D = 0; HMASTER_S = 0; HWDATA_S = 0. Reset mid-transfer discards any buffered request and data-phase ownership.
- live_m = (HTRANS_m[1] == 1) & HREADY_m. BUSY is treated as IDLE. SEQ is treated as NONSEQ.
- req_m = pend_m | live_m. The source for master m is its buffer when pend_m = 1, otherwise its live inputs.
- Arbitration occurs only in cycles with HREADY_S = 1 (slot). Winner selection:
  - D if req_D and not (starve & req_I);
  - otherwise I if req_I;
  - otherwise none, and HTRANS_S = IDLE.
  - starve = (STARVE_LIMIT != 0) & (wait_cnt >= STARVE_LIMIT).
- Slave address-phase outputs are a combinational mux of the winner's source. HTRANS_S = NONSEQ whenever a winner exists.
- At each slot edge: dp_valid <= (winner exists); dp_owner <= winner. The winner's pend clears.
- Capture: live_m & not (slot & winner == m) → buffer <= {HADDR, HWRITE, HSIZE, HPROT}_m and pend_m <= 1. Capture happens even when HREADY_S = 0. At most one entry per master, because HREADY_m = 0 while pend_m = 1.
- HREADY_m:
  - HREADY_S when dp_valid & dp_owner == m;
  - 0 when pend_m;
  - 1 otherwise.
- HRESP_m = HRESP_S when m is the data-phase owner, else 0.
- HWDATA_S = HWDATA_D when dp_valid & dp_owner == D, else 0. D holds HWDATA while HREADY_D = 0, so buffered stores need no data buffer.
- wait_cnt, per slot:
  - +1 (saturating at STARVE_LIMIT) when I requests and loses;
  - cleared to 0 when I wins;
  - unchanged otherwise.
- Simultaneous live requests with both buffers empty: D is issued and I is captured. I issues in the next slot unless D requests again and not starve.
- Error: HRESP_S is forwarded to the owner for both cycles. A pending buffer of the other master is unaffected.
- Latency: an uncontended request reaches the slave in the same cycle (0 added). A buffered request adds ≥1 wait state.

Decomposition:
- Shared package ahb_defs holds the HTRANS/HSIZE/HBURST/HPROT constants (IDLE, BUSY, NONSEQ, SEQ, BYTE, HALFWORD, WORD, SINGLE, HPROT_DATA), reused by the memory and fetch stages.
- One sub-module, ahb_req_buffer, instantiated twice: holding register, pend flag, and source mux for a single master.
- Arbitration, wait_cnt, and data-phase routing stay in the top.

Test Plan:
- Idle, then D LW 0x100 alone with HREADY_S = 1 → HADDR_S = 0x100, HMASTER_S = 1 the same cycle; HREADY_D = 1; HRDATA_D = slave data next cycle; no wait states.
- I and D NONSEQ in the same cycle (0x0 / 0x200) → D issued first; pend_I = 1; HREADY_I = 0 for 1 cycle; I's 0x0 issued the next cycle, taken from the buffer while I holds 0x4 on its live inputs.
- D requests every cycle, I requests continuously, STARVE_LIMIT = 4 → I granted exactly once after 4 lost slots; wait_cnt returns to 0; D is then buffered one cycle.
- D SW 0x300 data 0xDEADBEEF while I's data phase has HREADY_S = 0 for 3 cycles → D captured, HREADY_D = 0; SW issued when HREADY_S rises; HWDATA_S = 0xDEADBEEF in its data phase.
- D read with HRESP_S = 1 for 2 cycles → HRESP_D = 1 on both; HRESP_I = 0; I's pending request still issues afterwards.
- RSTn low while pend_I = 1 and a D data phase is active → outputs immediately take their reset values, HTRANS_S = IDLE; after release, no stale transfer issues.
